// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch inputs, writeback write port and every ID/EX-bound output.
// master = surrounding pipeline (drives fetch/writeback), slave = decode_stage.
interface decode_stage_if;
   logic [31:0] instrF;
   logic [31:0] pcplus4F;
   logic        stallD;
   logic        flushD;
   logic        regwriteW;
   logic [4:0]  writeregW;
   logic [31:0] resultW;

   logic [31:0] instrD;
   logic [31:0] pcplus4D;
   logic [31:0] rd1D;
   logic [31:0] rd2D;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic [4:0]  RdD;
   logic [31:0] signimmD;
   logic        regwriteD;
   logic        memtoregD;
   logic        memwriteD;
   logic        branchD;
   logic        alusrcD;
   logic        regdstD;
   logic        jumpD;
   logic [2:0]  alucontrolD;
   logic        illegalD;

   modport master (
      output instrF, pcplus4F, stallD, flushD, regwriteW, writeregW, resultW,
      input  instrD, pcplus4D, rd1D, rd2D, RsD, RtD, RdD, signimmD,
      input  regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD, jumpD,
      input  alucontrolD, illegalD
   );

   modport slave (
      input  instrF, pcplus4F, stallD, flushD, regwriteW, writeregW, resultW,
      output instrD, pcplus4D, rd1D, rd2D, RsD, RtD, RdD, signimmD,
      output regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD, jumpD,
      output alucontrolD, illegalD
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file, main/ALU
// decoder and sign extender.
// Optional macro REGFILE_BYPASS_EN: forward the writeback value to same-cycle reads.
module decode_stage (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);

   logic [31:0] instr_q;
   logic [31:0] pcplus4_q;
   logic [31:0] regs [32];

   logic [4:0]  rs, rt;
   logic [5:0]  opcode, funct;
   logic [1:0]  aluop;
   logic        regwrite, memtoreg, memwrite, branch, alusrc, regdst, jump, illegal;
   logic [2:0]  alucontrol;
   logic [31:0] rd1, rd2;

   assign rs     = instr_q[25:21];
   assign rt     = instr_q[20:16];
   assign opcode = instr_q[31:26];
   assign funct  = instr_q[5:0];

   // IF/ID register: flush beats stall beats load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q   <= '0;
         pcplus4_q <= '0;
      end else if (bus.flushD) begin
         instr_q   <= '0;
         pcplus4_q <= '0;
      end else if (!bus.stallD) begin
         instr_q   <= bus.instrF;
         pcplus4_q <= bus.pcplus4F;
      end
   end

   // Register file write port; register 0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (bus.regwriteW && (bus.writeregW != 5'd0)) begin
         regs[bus.writeregW] <= bus.resultW;
      end
   end

   // Combinational reads; register 0 is hard-wired to zero
   always_comb begin
      rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
      rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
      // writeregW != 0 guard keeps register 0 reading zero under bypass
      if (bus.regwriteW && (bus.writeregW != 5'd0) && (bus.writeregW == rs)) rd1 = bus.resultW;
      if (bus.regwriteW && (bus.writeregW != 5'd0) && (bus.writeregW == rt)) rd2 = bus.resultW;
`endif
   end

   // Main decoder followed by ALU decoder
   always_comb begin
      regwrite   = 1'b0;
      memtoreg   = 1'b0;
      memwrite   = 1'b0;
      branch     = 1'b0;
      alusrc     = 1'b0;
      regdst     = 1'b0;
      jump       = 1'b0;
      illegal    = 1'b0;
      aluop      = 2'b00;
      alucontrol = 3'b000;
      // The all-zero NOP would otherwise decode as an R-type with an illegal funct
      if (instr_q != 32'd0) begin
         unique case (opcode)
            6'b000000: begin regwrite = 1'b1; regdst = 1'b1; aluop = 2'b10; end
            6'b100011: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
            6'b101011: begin memwrite = 1'b1; alusrc = 1'b1; end
            6'b000100: begin branch = 1'b1; aluop = 2'b01; end
            6'b001000: begin regwrite = 1'b1; alusrc = 1'b1; end
            6'b000010: jump = 1'b1;
            default:   illegal = 1'b1;
         endcase
         if (!illegal && !jump) begin
            unique case (aluop)
               2'b00:   alucontrol = 3'b010;
               2'b01:   alucontrol = 3'b110;
               default: begin
                  unique case (funct)
                     6'b100000: alucontrol = 3'b010;
                     6'b100010: alucontrol = 3'b110;
                     6'b100100: alucontrol = 3'b000;
                     6'b100101: alucontrol = 3'b001;
                     6'b101010: alucontrol = 3'b111;
                     default: begin
                        regwrite   = 1'b0;
                        alucontrol = 3'b000;
                        illegal    = 1'b1;
                     end
                  endcase
               end
            endcase
         end
      end
   end

   assign bus.instrD      = instr_q;
   assign bus.pcplus4D    = pcplus4_q;
   assign bus.rd1D        = rd1;
   assign bus.rd2D        = rd2;
   assign bus.RsD         = rs;
   assign bus.RtD         = rt;
   assign bus.RdD         = instr_q[15:11];
   assign bus.signimmD    = {{16{instr_q[15]}}, instr_q[15:0]};
   assign bus.regwriteD   = regwrite;
   assign bus.memtoregD   = memtoreg;
   assign bus.memwriteD   = memwrite;
   assign bus.branchD     = branch;
   assign bus.alusrcD     = alusrc;
   assign bus.regdstD     = regdst;
   assign bus.jumpD       = jump;
   assign bus.alucontrolD = alucontrol;
   assign bus.illegalD    = illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected IF/ID contents and
// decodes, plus a register-file model for read-data checks.
module tb_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [10:0] ctrl;
      logic [31:0] imm;
   } exp_t;

   logic clk;
   logic rst_n;
   decode_stage_if bus ();

   decode_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb [$];
   logic [31:0] rf_model [32];

   logic [10:0] dut_ctrl;
   assign dut_ctrl = {bus.regwriteD, bus.memtoregD, bus.memwriteD, bus.branchD, bus.alusrcD,
                      bus.regdstD, bus.jumpD, bus.alucontrolD, bus.illegalD};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {regwrite, memtoreg, memwrite, branch, alusrc, regdst, jump, alucontrol[2:0], illegal}
   function automatic logic [10:0] exp_ctrl(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (ins == 32'd0) return 11'b0;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100000: return 11'b1000010_010_0;
               6'b100010: return 11'b1000010_110_0;
               6'b100100: return 11'b1000010_000_0;
               6'b100101: return 11'b1000010_001_0;
               6'b101010: return 11'b1000010_111_0;
               default:   return 11'b0000010_000_1;
            endcase
         end
         6'b100011: return 11'b1100100_010_0;
         6'b101011: return 11'b0010100_010_0;
         6'b000100: return 11'b0001000_110_0;
         6'b001000: return 11'b1000100_010_0;
         6'b000010: return 11'b0000001_000_0;
         default:   return 11'b0000000_000_1;
      endcase
   endfunction

   // Drive one fetch, push its expectation, compare after the capturing edge
   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      bus.instrF   = ins;
      bus.pcplus4F = pc;
      e.instr = ins;
      e.pc    = pc;
      e.ctrl  = exp_ctrl(ins);
      e.imm   = {{16{ins[15]}}, ins[15:0]};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("instrD", bus.instrD, e.instr);
         check("pcplus4D", bus.pcplus4D, e.pc);
         check("ctrl", {21'd0, dut_ctrl}, {21'd0, e.ctrl});
         check("signimmD", bus.signimmD, e.imm);
         check("RsD", {27'd0, bus.RsD}, {27'd0, e.instr[25:21]});
         check("RtD", {27'd0, bus.RtD}, {27'd0, e.instr[20:16]});
         check("RdD", {27'd0, bus.RdD}, {27'd0, e.instr[15:11]});
         check("rd1D", bus.rd1D, rf_model[e.instr[25:21]]);
         check("rd2D", bus.rd2D, rf_model[e.instr[20:16]]);
      end
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] data);
      bus.regwriteW = 1'b1;
      bus.writeregW = idx;
      bus.resultW   = data;
      @(posedge clk);
      #1;
      bus.regwriteW = 1'b0;
      if (idx != 5'd0) rf_model[idx] = data;
      @(negedge clk);
   endtask

   logic [31:0] ops [10];

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
      ops = '{32'hAC09_0008, 32'h1129_0003, 32'h0800_0010, 32'h0129_4022, 32'h0129_4024,
              32'h0129_4025, 32'h0129_402A, 32'h0129_4021, 32'hFC00_0000, 32'h0000_0000};
      rst_n         = 1'b0;
      bus.instrF    = 32'd0;
      bus.pcplus4F  = 32'd0;
      bus.stallD    = 1'b0;
      bus.flushD    = 1'b0;
      bus.regwriteW = 1'b0;
      bus.writeregW = 5'd0;
      bus.resultW   = 32'd0;

      #2;
      check("rst_instrD", bus.instrD, 32'd0);
      check("rst_pcplus4D", bus.pcplus4D, 32'd0);
      check("rst_ctrl", {21'd0, dut_ctrl}, 32'd0);
      check("rst_rd1D", bus.rd1D, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw $8,4($0)
      issue(32'h8C08_0004, 32'h0000_0004);
      check("lw_alucontrol", {29'd0, bus.alucontrolD}, 32'd2);
      check("lw_RtD", {27'd0, bus.RtD}, 32'd8);

      // add $8,$9,$9 after writing $9
      wr(5'd9, 32'hDEAD_BEEF);
      issue(32'h0129_4020, 32'h0000_0008);
      check("add_rd1D", bus.rd1D, 32'hDEAD_BEEF);
      check("add_rd2D", bus.rd2D, 32'hDEAD_BEEF);

      // Same-cycle write to a register being read
      bus.regwriteW = 1'b1;
      bus.writeregW = 5'd9;
      bus.resultW   = 32'h1234_5678;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("same_cycle_rd1D", bus.rd1D, 32'h1234_5678);
`else
      check("same_cycle_rd1D", bus.rd1D, 32'hDEAD_BEEF);
`endif
      @(posedge clk);
      #1;
      bus.regwriteW = 1'b0;
      rf_model[9]   = 32'h1234_5678;
      check("after_write_rd1D", bus.rd1D, 32'h1234_5678);
      @(negedge clk);

      // Register 0 ignores writes, also when written in the reading cycle
      wr(5'd0, 32'hFFFF_FFFF);
      issue(32'h2008_FFFF, 32'h0000_000C);
      bus.regwriteW = 1'b1;
      bus.writeregW = 5'd0;
      bus.resultW   = 32'hFFFF_FFFF;
      #1;
      check("r0_bypass_rd1D", bus.rd1D, 32'd0);
      @(posedge clk);
      #1;
      bus.regwriteW = 1'b0;
      check("r0_after_rd1D", bus.rd1D, 32'd0);
      @(negedge clk);

      // Stall holds, flush beats stall
      bus.stallD   = 1'b1;
      bus.instrF   = 32'hAC09_0008;
      bus.pcplus4F = 32'h0000_0010;
      @(posedge clk);
      #1;
      check("stall_instrD", bus.instrD, 32'h2008_FFFF);
      check("stall_pcplus4D", bus.pcplus4D, 32'h0000_000C);
      @(negedge clk);
      bus.flushD = 1'b1;
      @(posedge clk);
      #1;
      check("flush_instrD", bus.instrD, 32'd0);
      check("flush_pcplus4D", bus.pcplus4D, 32'd0);
      check("flush_ctrl", {21'd0, dut_ctrl}, 32'd0);
      @(negedge clk);
      bus.stallD = 1'b0;
      bus.flushD = 1'b0;

      // Remaining opcodes and functs, legal and illegal
      foreach (ops[i]) issue(ops[i], 32'h0000_0100 + 32'(i) * 4);

      // Mid-cycle reset wipes IF/ID and register state immediately
      wr(5'd10, 32'hCAFE_F00D);
      issue(32'h014A_5820, 32'h0000_0200);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_instrD", bus.instrD, 32'd0);
      check("midrst_pcplus4D", bus.pcplus4D, 32'd0);
      check("midrst_rd1D", bus.rd1D, 32'd0);
      check("midrst_ctrl", {21'd0, dut_ctrl}, 32'd0);
      for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h014A_5820, 32'h0000_0204);
      check("postrst_rd1D", bus.rd1D, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline: holds the IF/ID pipeline register, the 32×32 register file, the main/ALU control decoder and the sign extender. It consumes the fetched instruction and PC+4 and produces every `*D` operand and control signal captured by the ID/EX register. The register file's write port is driven from writeback.

## Interface
Parameters: none; widths fixed at 32-bit datapath, 5-bit register index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instrF  in  32  fetched instruction
- pcplus4F  in  32  fetch PC+4
- stallD  in  1  hold IF/ID contents
- flushD  in  1  load NOP into IF/ID
- regwriteW  in  1  writeback write enable
- writeregW  in  5  writeback destination
- resultW  in  32  writeback data
- instrD  out  32  registered instruction
- pcplus4D  out  32  registered PC+4
- rd1D, rd2D  out  32  register file read data (rs, rt)
- RsD, RtD, RdD  out  5  instrD[25:21], [20:16], [15:11]
- signimmD  out  32  sign-extended instrD[15:0]
- regwriteD, memtoregD, memwriteD, branchD, alusrcD, regdstD, jumpD  out  1  decoded controls
- alucontrolD  out  3  ALU operation
- illegalD  out  1  unsupported opcode/funct

## Operation
- IF/ID register: on posedge, priority flushD > stallD > load. Flush loads instrD=0, pcplus4D=0. Stall holds. Otherwise instrD←instrF, pcplus4D←pcplus4F.
- Instruction 0x00000000 is NOP: all controls 0, alucontrolD=000, illegalD=0.
- Main decode of instrD[31:26]:
  - R-type 000000: regwrite, regdst, aluop=10.
  - lw 100011: regwrite, alusrc, memtoreg, aluop=00.
  - sw 101011: memwrite, alusrc, aluop=00.
  - beq 000100: branch, aluop=01.
  - addi 001000: regwrite, alusrc, aluop=00.
  - j 000010: jump; all other controls 0.
  - Any other opcode: all controls 0, alucontrolD=000, illegalD=1.
- ALU decode:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Other funct (instrD≠0): regwriteD forced 0, alucontrolD=000, illegalD=1.
- signimmD = {{16{instrD[15]}}, instrD[15:0]}.
- Register file: 32 entries.
  - Write on posedge when regwriteW=1 and writeregW≠0.
  - Reads are combinational, indexed by RsD/RtD.
  - Register 0 always reads 0.

## Timing
- Async reset (rst_n=0): instrD=0, pcplus4D=0, all 32 registers=0. All outputs therefore read 0 (NOP decode). Effective immediately, regardless of clk. Reset asserted mid-stream discards in-flight IF/ID contents and register state.
- Latency: instrF → decoded outputs valid one posedge later (combinational from instrD). Decode outputs must settle within the same cycle to meet ID/EX setup.
- Register write at posedge N is visible to reads from cycle N onward. Same-cycle read/write behaviour is set by the Configuration macro.
- Write to register 0 is ignored. Read of register 0 returns 0 even under bypass.
- stallD and flushD never affect the register file.

## Configuration
- REGFILE_BYPASS_EN defined: when regwriteW=1, writeregW≠0 and writeregW equals RsD (or RtD), rd1D (or rd2D) returns resultW combinationally in the same cycle as the write.
- Not defined: same-cycle reads return the old stored value. The hazard unit must then stall one extra cycle on a W→D dependency.

## Test plan
- Reset then release; load instrF=0x8C080004 (lw $8,4($0)) → next cycle: regwriteD=1, alusrcD=1, memtoregD=1, regdstD=0, alucontrolD=010, RtD=8, signimmD=0x00000004.
- Write resultW=0xDEADBEEF to reg 9. Then decode 0x01294020 (add $8,$9,$9) → rd1D=rd2D=0xDEADBEEF, alucontrolD=010, regdstD=1, RdD=8.
- Same cycle: regwriteW=1, writeregW=9, resultW=0x12345678, with instrD reading $9 → rd1D=0x12345678 with REGFILE_BYPASS_EN, old value without it.
- Write 0xFFFFFFFF to reg 0 → rd1D=0 when RsD=0. Decode 0x2008FFFF (addi) → signimmD=0xFFFFFFFF.
- stallD=1 with new instrF → instrD unchanged. stallD=1 and flushD=1 together → instrD=0, all controls 0. Opcode 111111 → illegalD=1, all controls 0.
- Assert rst_n=0 mid-cycle after register writes → outputs and all registers read 0 immediately, before the next clk edge.
